// File: rtl/stage_task_responder.sv
// stage_task_responder: per-stage responder for the game-flow handshake.
// Executes clear / tower draw / car tally / end hold and returns level-held done flags.
`default_nettype none

module stage_task_responder #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter int          TOWER_X      = 72,
    parameter int          TOWER_Y      = 52,
    parameter int          TOWER_SIZE   = 8,
    parameter logic [2:0]  TOWER_COLOUR = 3'b010,
    parameter int          NUM_CARS     = 4,
    parameter int          LIVES        = 3,
    parameter int          END_HOLD     = 50000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_begin,
    input  logic       cmd_draw_tower,
    input  logic       cmd_in_progress,
    input  logic       cmd_done,
    input  logic       car_killed,
    input  logic       car_escaped,
    output logic       begin_done,
    output logic       tower_done,
    output logic       car_done,
    output logic       end_display_done,
    output logic       game_over,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [1:0] lives_left
);

    localparam int RW = $clog2(NUM_CARS + 2);
    localparam int EW = $clog2(LIVES + 1);
    localparam int HW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

    localparam logic [7:0]    X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [6:0]    Y_LAST    = 7'(SCREEN_H - 1);
    localparam logic [7:0]    TX_FIRST  = 8'(TOWER_X);
    localparam logic [7:0]    TX_LAST   = 8'(TOWER_X + TOWER_SIZE - 1);
    localparam logic [6:0]    TY_FIRST  = 7'(TOWER_Y);
    localparam logic [6:0]    TY_LAST   = 7'(TOWER_Y + TOWER_SIZE - 1);
    localparam logic [RW-1:0] CARS_C    = RW'(NUM_CARS);
    localparam logic [EW-1:0] LIVES_C   = EW'(LIVES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CLEAR     = 4'd1,
        CLEAR_ACK = 4'd2,
        TOWER     = 4'd3,
        TOWER_ACK = 4'd4,
        PLAY      = 4'd5,
        PLAY_ACK  = 4'd6,
        HOLD      = 4'd7,
        HOLD_ACK  = 4'd8
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    x_nxt;
    logic [6:0]    y_nxt;
    logic [2:0]    colour_nxt;
    logic          plot_nxt;
    logic          begin_done_nxt, tower_done_nxt, car_done_nxt;
    logic          end_display_done_nxt, game_over_nxt;
    logic [1:0]    lives_left_nxt;
    logic [RW-1:0] resolved, resolved_nxt, res_sum;
    logic [EW-1:0] escaped, escaped_nxt, esc_sum;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            x                <= '0;
            y                <= '0;
            colour           <= '0;
            plot             <= 1'b0;
            begin_done       <= 1'b0;
            tower_done       <= 1'b0;
            car_done         <= 1'b0;
            end_display_done <= 1'b0;
            game_over        <= 1'b0;
            lives_left       <= 2'(LIVES);
            resolved         <= '0;
            escaped          <= '0;
            hold_cnt         <= '0;
        end else begin
            state            <= state_nxt;
            x                <= x_nxt;
            y                <= y_nxt;
            colour           <= colour_nxt;
            plot             <= plot_nxt;
            begin_done       <= begin_done_nxt;
            tower_done       <= tower_done_nxt;
            car_done         <= car_done_nxt;
            end_display_done <= end_display_done_nxt;
            game_over        <= game_over_nxt;
            lives_left       <= lives_left_nxt;
            resolved         <= resolved_nxt;
            escaped          <= escaped_nxt;
            hold_cnt         <= hold_cnt_nxt;
        end
    end

    // All outputs are computed for the next state and registered.
    always_comb begin
        state_nxt            = state;
        x_nxt                = x;
        y_nxt                = y;
        colour_nxt           = colour;
        plot_nxt             = 1'b0;
        begin_done_nxt       = 1'b0;
        tower_done_nxt       = 1'b0;
        car_done_nxt         = 1'b0;
        end_display_done_nxt = 1'b0;
        game_over_nxt        = game_over;
        lives_left_nxt       = lives_left;
        resolved_nxt         = resolved;
        escaped_nxt          = escaped;
        hold_cnt_nxt         = hold_cnt;
        res_sum              = resolved + RW'(car_killed) + RW'(car_escaped);
        esc_sum              = escaped + EW'(car_escaped);

        case (state)
            IDLE: begin
                x_nxt = '0;
                y_nxt = '0;
                if (cmd_begin) begin
                    state_nxt  = CLEAR;
                    colour_nxt = 3'b000;
                    plot_nxt   = 1'b1;
                end else if (cmd_draw_tower) begin
                    state_nxt  = TOWER;
                    x_nxt      = TX_FIRST;
                    y_nxt      = TY_FIRST;
                    colour_nxt = TOWER_COLOUR;
                    plot_nxt   = 1'b1;
                end else if (cmd_in_progress) begin
                    state_nxt      = PLAY;
                    resolved_nxt   = '0;
                    escaped_nxt    = '0;
                    lives_left_nxt = 2'(LIVES);
                end else if (cmd_done) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = '0;
                end else begin
                    x_nxt = x;
                    y_nxt = y;
                end
            end

            CLEAR: begin
                if (!cmd_begin) begin
                    state_nxt = IDLE;
                end else if (x == X_LAST && y == Y_LAST) begin
                    state_nxt      = CLEAR_ACK;
                    begin_done_nxt = 1'b1;
                end else begin
                    plot_nxt = 1'b1;
                    if (x == X_LAST) begin
                        x_nxt = '0;
                        y_nxt = y + 7'd1;
                    end else begin
                        x_nxt = x + 8'd1;
                    end
                end
            end

            CLEAR_ACK: begin
                if (cmd_begin) begin
                    begin_done_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            TOWER: begin
                if (!cmd_draw_tower) begin
                    state_nxt = IDLE;
                end else if (x == TX_LAST && y == TY_LAST) begin
                    state_nxt      = TOWER_ACK;
                    tower_done_nxt = 1'b1;
                end else begin
                    plot_nxt = 1'b1;
                    if (x == TX_LAST) begin
                        x_nxt = TX_FIRST;
                        y_nxt = y + 7'd1;
                    end else begin
                        x_nxt = x + 8'd1;
                    end
                end
            end

            TOWER_ACK: begin
                if (cmd_draw_tower) begin
                    tower_done_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            PLAY: begin
                if (!cmd_in_progress) begin
                    state_nxt = IDLE;
                end else begin
                    resolved_nxt   = res_sum;
                    escaped_nxt    = esc_sum;
                    lives_left_nxt = (esc_sum >= LIVES_C) ? 2'd0 : 2'(LIVES_C - esc_sum);
                    // Running out of lives outranks finishing the wave.
                    if (esc_sum >= LIVES_C) begin
                        state_nxt     = PLAY_ACK;
                        game_over_nxt = 1'b1;
                    end else if (res_sum >= CARS_C) begin
                        state_nxt    = PLAY_ACK;
                        car_done_nxt = 1'b1;
                    end
                end
            end

            PLAY_ACK: begin
                if (cmd_in_progress) begin
                    car_done_nxt = car_done;
                end else begin
                    state_nxt = IDLE;
                end
            end

            HOLD: begin
                if (!cmd_done) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt            = HOLD_ACK;
                    end_display_done_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HW'(1);
                end
            end

            HOLD_ACK: begin
                if (cmd_done) begin
                    end_display_done_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_stage_task_responder.sv
// tb_stage_task_responder: directed bench with a pixel scoreboard for the stage responder.
`default_nettype none

module tb_stage_task_responder;

    localparam int END_HOLD_TB = 10;

    logic       clk;
    logic       resetn;
    logic       cmd_begin, cmd_draw_tower, cmd_in_progress, cmd_done;
    logic       car_killed, car_escaped;
    logic       begin_done, tower_done, car_done, end_display_done, game_over;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [1:0] lives_left;

    int tests = 0;
    int fails = 0;
    logic [17:0] exp_q[$];

    stage_task_responder #(.END_HOLD(END_HOLD_TB)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cmd_begin        (cmd_begin),
        .cmd_draw_tower   (cmd_draw_tower),
        .cmd_in_progress  (cmd_in_progress),
        .cmd_done         (cmd_done),
        .car_killed       (car_killed),
        .car_escaped      (car_escaped),
        .begin_done       (begin_done),
        .tower_done       (tower_done),
        .car_done         (car_done),
        .end_display_done (end_display_done),
        .game_over        (game_over),
        .x                (x),
        .y                (y),
        .colour           (colour),
        .plot             (plot),
        .lives_left       (lives_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                exp_q.push_back({8'(xx), 7'(yy), 3'b000});
    endtask

    task automatic push_tower();
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++)
                exp_q.push_back({8'(72 + dx), 7'(52 + dy), 3'b010});
    endtask

    // Each cycle must carry a write matching the next expected pixel.
    task automatic run_plot(input string tag, input int n);
        logic [17:0] e;
        for (int i = 0; i < n; i++) begin
            step();
            e = exp_q.pop_front();
            check(tag, 32'({plot, x, y, colour}), 32'({1'b1, e}));
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({begin_done, tower_done, car_done, end_display_done, game_over});
    endfunction

    initial begin
        logic seen;
        resetn = 1'b0;
        cmd_begin = 1'b0; cmd_draw_tower = 1'b0; cmd_in_progress = 1'b0; cmd_done = 1'b0;
        car_killed = 1'b0; car_escaped = 1'b0;
        #23;
        check("rst_pix", 32'({plot, x, y, colour}), 32'd0);
        check("rst_flags", flags(), 32'd0);
        check("rst_lives", 32'(lives_left), 32'd3);
        resetn = 1'b1;
        step();

        // Full screen clear
        push_clear();
        cmd_begin = 1'b1;
        run_plot("clear_px", exp_q.size());
        step();
        check("clear_done", 32'({begin_done, plot}), 32'b10);
        step();
        check("clear_done_hold", 32'(begin_done), 32'd1);
        cmd_begin = 1'b0;
        step();
        check("clear_done_drop", 32'(begin_done), 32'd0);
        step();
        check("idle_after_clear", 32'({plot, flags()}), 32'd0);

        // Tower sprite
        push_tower();
        cmd_draw_tower = 1'b1;
        run_plot("tower_px", exp_q.size());
        step();
        check("tower_done", 32'({tower_done, plot}), 32'b10);
        step(); step(); step();
        check("tower_done_hold", 32'(tower_done), 32'd1);
        cmd_draw_tower = 1'b0;
        step();
        check("tower_done_drop", 32'(tower_done), 32'd0);

        // Play: three kills, then a kill and an escape together
        cmd_in_progress = 1'b1;
        step();
        check("play1_entry", 32'({lives_left, car_done, game_over, plot}), 32'b11000);
        for (int i = 0; i < 3; i++) begin
            car_killed = 1'b1; step(); car_killed = 1'b0;
        end
        check("play1_not_done", 32'(car_done), 32'd0);
        car_killed = 1'b1; car_escaped = 1'b1;
        step();
        car_killed = 1'b0; car_escaped = 1'b0;
        check("play1_result", 32'({car_done, game_over, lives_left}), 32'b1010);
        step();
        check("play1_hold", 32'(car_done), 32'd1);
        cmd_in_progress = 1'b0;
        step();
        check("play1_drop", 32'(car_done), 32'd0);

        // Play: third escape arrives with the fourth resolved car
        cmd_in_progress = 1'b1;
        step();
        check("play2_entry", 32'(lives_left), 32'd3);
        car_killed = 1'b1; step(); car_killed = 1'b0;
        car_escaped = 1'b1; step();
        step();
        check("play2_lives1", 32'({lives_left, game_over, car_done}), 32'b0100);
        step();
        car_escaped = 1'b0;
        check("play2_over", 32'({game_over, car_done, lives_left}), 32'b1000);
        cmd_in_progress = 1'b0;
        step(); step();
        check("game_over_sticky", 32'({game_over, car_done}), 32'b10);

        // End-screen hold to completion
        cmd_done = 1'b1;
        step();
        for (int i = 1; i < END_HOLD_TB; i++) begin
            step();
            check("hold_wait", 32'(end_display_done), 32'd0);
        end
        step();
        check("hold_done", 32'(end_display_done), 32'd1);
        cmd_done = 1'b0;
        step();
        check("hold_drop", 32'(end_display_done), 32'd0);

        // End-screen hold abandoned at cycle 5
        cmd_done = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        cmd_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen = seen | end_display_done | plot;
        end
        check("hold_abort", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a clear
        push_clear();
        cmd_begin = 1'b1;
        run_plot("clear2_px", 500);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_pix", 32'({plot, x, y}), 32'd0);
        check("async_rst_flags", flags(), 32'd0);
        check("async_rst_lives", 32'(lives_left), 32'd3);
        exp_q.delete();
        #2;
        resetn = 1'b1;
        push_clear();
        run_plot("clear3_px", exp_q.size());
        step();
        check("clear3_done", 32'({begin_done, plot}), 32'b10);
        cmd_begin = 1'b0;
        step();
        check("clear3_drop", 32'(begin_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
